// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller.
// Runs a single outstanding req/ack transaction with data memory, aligns store
// lanes, extends load data and stalls the pipeline while an access is in flight.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic [31:0] read_mem_data_out,
    output logic        stall_req,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Last BUSY count value before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdout_q, rdout_d;
    logic        bus_err_q, bus_err_d;

    logic        op, mis, is_half, is_word;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Decode the incoming access; size 11 behaves as a word.
    always_comb begin
        is_half = (mem_size_in == 2'b01);
        is_word = mem_size_in[1];
        op      = valid_in & (mem_read_in | mem_write_in);
        mis     = op & ((is_half & addr_in[0]) | (is_word & (addr_in[1:0] != 2'b00)));
    end

    // Little-endian store lane replication and byte enables; loads enable all lanes.
    always_comb begin
        st_wdata = store_data_in;
        st_be    = 4'b1111;
        if (mem_write_in) begin
            case (mem_size_in)
                2'b00: begin
                    st_wdata = {4{store_data_in[7:0]}};
                    st_be    = 4'b0001 << addr_in[1:0];
                end
                2'b01: begin
                    st_wdata = {2{store_data_in[15:0]}};
                    st_be    = addr_in[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = store_data_in;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    // Select the addressed lane of the returned word and extend it; stores return 0.
    always_comb begin
        ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
        if (we_q) begin
            ld_ext = 32'h0;
        end
    end

    // Next-state logic and combinational pipeline controls.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        lane_d    = lane_q;
        size_d    = size_q;
        uns_d     = uns_q;
        rdout_d   = rdout_q;
        bus_err_d = 1'b0;
        stall_req = 1'b0;
        addr_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                addr_err = mis;
                if (op && !mis) begin
                    stall_req = 1'b1;
                    req_d     = 1'b1;
                    we_d      = mem_write_in;
                    addr_d    = {addr_in[31:2], 2'b00};
                    wdata_d   = st_wdata;
                    be_d      = st_be;
                    lane_d    = addr_in[1:0];
                    size_d    = mem_size_in;
                    uns_d     = mem_unsigned_in;
                    cnt_d     = 8'd0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                if (dmem_ack) begin
                    rdout_d = ld_ext;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdout_d   = 32'h0;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered-output storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            lane_q    <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            rdout_q   <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            lane_q    <= lane_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            rdout_q   <= rdout_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_wdata        = wdata_q;
    assign dmem_be           = be_q;
    assign read_mem_data_out = rdout_q;
    assign bus_err           = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of load/store vectors plus
// hand-written reset-mid-access and bus-timeout sequences.
module tb_mem_access_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read_in, mem_write_in, mem_unsigned_in;
    logic [1:0]  mem_size_in;
    logic [31:0] addr_in, store_data_in;
    logic [31:0] read_mem_data_out;
    logic        stall_req, addr_err, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_in          (valid_in),
        .mem_read_in       (mem_read_in),
        .mem_write_in      (mem_write_in),
        .mem_size_in       (mem_size_in),
        .mem_unsigned_in   (mem_unsigned_in),
        .addr_in           (addr_in),
        .store_data_in     (store_data_in),
        .read_mem_data_out (read_mem_data_out),
        .stall_req         (stall_req),
        .addr_err          (addr_err),
        .bus_err           (bus_err),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [3:0]  delay;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        chk_wdata;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdout;
        logic        mis;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        valid_in        = 1'b0;
        mem_read_in     = 1'b0;
        mem_write_in    = 1'b0;
        mem_size_in     = 2'b00;
        mem_unsigned_in = 1'b0;
        addr_in         = 32'h0;
        store_data_in   = 32'h0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic       is_op;
        int         stall_cnt;
        logic [31:0] exp_rd;
        is_op = v.rd | v.wr;
        @(negedge clk);
        valid_in        = 1'b1;
        mem_read_in     = v.rd;
        mem_write_in    = v.wr;
        mem_size_in     = v.size;
        mem_unsigned_in = v.uns;
        addr_in         = v.addr;
        store_data_in   = v.sdata;
        #1;
        check("addr_err", idx, {31'd0, addr_err}, {31'd0, v.mis});
        check("stall_idle", idx, {31'd0, stall_req}, {31'd0, is_op & ~v.mis});
        if (v.mis || !is_op) begin
            @(negedge clk);
            check("no_req", idx, {31'd0, dmem_req}, 32'd0);
            check("rdout_kept", idx, read_mem_data_out, v.exp_rdout);
            drive_idle();
            $display("vec %0d addr %h no access, rdout %h", idx, v.addr, read_mem_data_out);
            return;
        end
        sb_q.push_back(v.exp_rdout);
        stall_cnt = stall_req ? 1 : 0;
        for (int k = 1; k <= int'(v.delay); k++) begin
            @(negedge clk);
            if (stall_req) stall_cnt++;
            check("busy_req", idx, {31'd0, dmem_req}, 32'd1);
            if (k == 1) begin
                check("dmem_addr", idx, dmem_addr, v.exp_addr);
                check("dmem_be", idx, {28'd0, dmem_be}, {28'd0, v.exp_be});
                check("dmem_we", idx, {31'd0, dmem_we}, {31'd0, v.wr});
                if (v.chk_wdata) check("dmem_wdata", idx, dmem_wdata, v.exp_wdata);
            end
            if (k == int'(v.delay)) begin
                dmem_ack   = 1'b1;
                dmem_rdata = v.rdata;
            end
        end
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hDEAD_0000;
        check("stall_cycles", idx, stall_cnt, 1 + int'(v.delay));
        check("done_stall", idx, {31'd0, stall_req}, 32'd0);
        check("done_req", idx, {31'd0, dmem_req}, 32'd0);
        check("done_bus_err", idx, {31'd0, bus_err}, 32'd0);
        exp_rd = sb_q.pop_front();
        check("rdout", idx, read_mem_data_out, exp_rd);
        drive_idle();
        $display("vec %0d addr %h access done, rdout %h", idx, v.addr, read_mem_data_out);
    endtask

    initial begin
        int req_cycles;
        //              rd    wr    size   uns   addr          sdata         rdata         dly   exp_addr      be       cw    exp_wdata     exp_rdout     mis
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 4'd2, 32'h0000_1000, 4'b1111, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_0000, 4'd1, 32'h0000_2000, 4'b1111, 1'b0, 32'h0,        32'h0000_8001, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h0,        4'd3, 32'h0000_3000, 4'b0010, 1'b1, 32'hABAB_ABAB, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_BEEF, 32'h0,        4'd1, 32'h0000_3000, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0,        32'h0,         4'd0, 32'h0,         4'b0000, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_5000, 32'h0,        32'h1234_F00D, 4'd4, 32'h0000_5000, 4'b1111, 1'b0, 32'h0,        32'hFFFF_F00D, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_6002, 32'h0,        32'h00AB_0000, 4'd1, 32'h0000_6000, 4'b1111, 1'b0, 32'h0,        32'h0000_00AB, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_3003, 32'h1234_5678, 32'h0,        4'd1, 32'h0000_3000, 4'b1000, 1'b1, 32'h7878_7878, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,        4'd2, 32'h0000_7000, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_8004, 32'h0,        32'hCAFE_F00D, 4'd1, 32'h0000_8004, 4'b1111, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_8001, 32'h0,        32'h0,         4'd0, 32'h0,         4'b0000, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_9001, 32'h0,        32'h0,         4'd0, 32'h0,         4'b0000, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_A000, 32'h0,        32'h0000_007F, 4'd2, 32'h0000_A000, 4'b1111, 1'b0, 32'h0,        32'h0000_007F, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_B000, 32'h0,        32'h8000_0001, 4'd1, 32'h0000_B000, 4'b1111, 1'b0, 32'h0,        32'h8000_0001, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_B001, 32'h0,        32'h0,         4'd0, 32'h0,         4'b0000, 1'b0, 32'h0,        32'h8000_0001, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_C002, 32'h0,        32'h7FFF_8000, 4'd3, 32'h0000_C000, 4'b1111, 1'b0, 32'h0,        32'h0000_7FFF, 1'b0};

        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req", -1, {31'd0, dmem_req}, 32'd0);
        check("rst_rdout", -1, read_mem_data_out, 32'd0);
        check("rst_bus_err", -1, {31'd0, bus_err}, 32'd0);
        check("rst_stall", -1, {31'd0, stall_req}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset held two cycles while a load is outstanding; a late ack must be ignored.
        @(negedge clk);
        valid_in    = 1'b1;
        mem_read_in = 1'b1;
        mem_size_in = 2'b10;
        addr_in     = 32'h0000_D000;
        @(negedge clk);
        check("rstseq_busy", 100, {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        check("rstseq_req", 100, {31'd0, dmem_req}, 32'd0);
        check("rstseq_stall", 100, {31'd0, stall_req}, 32'd0);
        check("rstseq_addr", 100, dmem_addr, 32'd0);
        check("rstseq_wdata", 100, dmem_wdata, 32'd0);
        check("rstseq_be", 100, {28'd0, dmem_be}, 32'd0);
        check("rstseq_rdout", 100, read_mem_data_out, 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack_rdout", 100, read_mem_data_out, 32'd0);
        check("late_ack_req", 100, {31'd0, dmem_req}, 32'd0);
        check("late_ack_stall", 100, {31'd0, stall_req}, 32'd0);
        $display("reset sequence done, rdout %h", read_mem_data_out);

        // Load that sets a nonzero result, then a load that never gets acked.
        run_vec(101, vecs[9]);
        @(negedge clk);
        valid_in    = 1'b1;
        mem_read_in = 1'b1;
        mem_size_in = 2'b10;
        addr_in     = 32'h0000_E000;
        sb_q.push_back(32'h0);
        req_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!dmem_req) break;
            req_cycles++;
        end
        check("tmo_req_cycles", 102, req_cycles, TMO);
        check("tmo_bus_err", 102, {31'd0, bus_err}, 32'd1);
        check("tmo_stall", 102, {31'd0, stall_req}, 32'd0);
        check("tmo_rdout", 102, read_mem_data_out, sb_q.pop_front());
        drive_idle();
        @(negedge clk);
        check("tmo_bus_err_clr", 102, {31'd0, bus_err}, 32'd0);
        check("tmo_idle_req", 102, {31'd0, dmem_req}, 32'd0);
        $display("timeout sequence done, req cycles %0d", req_cycles);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
